// File: rtl/coin_pkg.sv
// Shared definitions for the coin sensor front end: debounce FSM state
// encodings and default parameter values.
package coin_pkg;

    // Per-channel debounce states. The encodings are fixed so that state
    // dumps from either channel read the same way in every tool.
    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        RISE_CHK    = 2'b01,
        HIGH_STABLE = 2'b10,
        FALL_CHK    = 2'b11
    } deb_state_e;

    // Default build: two-flop synchronizer, 16-sample debounce window.
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/coin_debounce.sv
// Single coin-sensor channel: synchronizer chain, debounce FSM and sample
// counter. rise_o flags the one cycle in which a debounced rising edge is
// confirmed; the parent registers its decision on that same clock edge, so
// the coin pulse appears in the cycle right after the FSM reaches
// HIGH_STABLE and the overall latency is SYNC_STAGES + DEBOUNCE_CYCLES.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,      // 2..3
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,  // 2..255
    parameter int CNT_W           = CNT_W_DEF             // 2**CNT_W > DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic rise_o
);

    // Last count value of a debounce window: DEBOUNCE_CYCLES identical
    // samples have been seen once the counter reaches this value and the
    // current sample still agrees.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    deb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Synchronizer chain: the raw line is only ever sampled by stage 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            // NOTE: clocked state is always updated with <=, so every flop
            // samples the pre-edge value of its neighbour and the chain
            // shifts by exactly one stage per clock.
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State and counter registers; reset discards any partial window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: count consecutive agreeing samples, restart on bounce.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so paths
        // that do not mention it hold the register value instead of
        // inferring a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW_STABLE: begin
                if (s) begin
                    state_d = RISE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!s) begin
                    state_d = FALL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: the rise event is the final confirming sample of RISE_CHK.
    always_comb begin
        rise_o = 1'b0;
        if ((state_q == RISE_CHK) && s && (cnt_q == CNT_LAST)) begin
            rise_o = 1'b1;
        end
    end

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin front end for the vending controller: debounces the dollar and
// quarter sensors and turns each accepted insertion into a single-cycle
// d_in / q_in pulse. Simultaneous or disabled insertions become a single
// coin_err pulse instead, so d_in and q_in are never high together.
module coin_pulse_gen
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_dollar,
    input  logic raw_quarter,
    input  logic accept_en,
    output logic d_in,
    output logic q_in,
    output logic coin_err
);

    logic rise_dollar;
    logic rise_quarter;

    logic d_in_q, d_in_d;
    logic q_in_q, q_in_d;
    logic err_q,  err_d;

    coin_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dollar (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (raw_dollar),
        .rise_o (rise_dollar)
    );

    coin_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_quarter (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (raw_quarter),
        .rise_o (rise_quarter)
    );

    // Arbitration: one lone, enabled rise passes through; anything else that
    // rises is rejected with exactly one error pulse.
    always_comb begin
        d_in_d = 1'b0;
        q_in_d = 1'b0;
        err_d  = 1'b0;
        if (rise_dollar && rise_quarter) begin
            err_d = 1'b1;
        end else if (rise_dollar || rise_quarter) begin
            if (accept_en) begin
                d_in_d = rise_dollar;
                q_in_d = rise_quarter;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Output registers: rise events last one cycle, so do the pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_in_q <= 1'b0;
            q_in_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            d_in_q <= d_in_d;
            q_in_q <= q_in_d;
            err_q  <= err_d;
        end
    end

    assign d_in     = d_in_q;
    assign q_in     = q_in_q;
    assign coin_err = err_q;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Self-checking bench for coin_pulse_gen with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Each insertion pushes the expected output pulse and
// the cycle it must appear in; a negedge monitor pops and compares every
// pulse the DUT produces and checks the output exclusivity every cycle.
module tb_coin_pulse_gen;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = SYNC + DEB;

    // Output pulse codes, {coin_err, q_in, d_in}.
    localparam logic [2:0] K_DOL = 3'b001;
    localparam logic [2:0] K_QTR = 3'b010;
    localparam logic [2:0] K_ERR = 3'b100;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic raw_dollar;
    logic raw_quarter;
    logic accept_en;
    logic d_in;
    logic q_in;
    logic coin_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    logic [2:0] obs;
    exp_t       got_e;

    coin_pulse_gen #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_dollar  (raw_dollar),
        .raw_quarter (raw_quarter),
        .accept_en   (accept_en),
        .d_in        (d_in),
        .q_in        (q_in),
        .coin_err    (coin_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called in the same negedge slot as the rising input: edge 1 is the
    // next posedge, so the pulse is seen at the negedge after edge LAT.
    task automatic expect_pulse(input logic [2:0] kind);
        exp_t e;
        e.cyc  = cyc + LAT;
        e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic flush(input string tag);
        tick(12);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        obs = {coin_err, q_in, d_in};
        check("exclusive", ($countones(obs) <= 1), 1);
        if (obs != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", obs, 0);
            end else begin
                got_e = sb.pop_front();
                check("pulse_kind", obs, got_e.kind);
                check("pulse_cycle", cyc, got_e.cyc);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        raw_dollar  = 1'b0;
        raw_quarter = 1'b0;
        accept_en   = 1'b1;
        #2 rst = 1'b0;
        #1 check("reset_outputs", {coin_err, q_in, d_in}, 0);
        tick(3);
        rst = 1'b1;
        tick(2);

        // 1. Clean dollar insertion.
        raw_dollar = 1'b1;
        expect_pulse(K_DOL);
        tick(20);
        raw_dollar = 1'b0;
        flush("s1_pending");

        // 2. Bouncy quarter, then a short low bounce while held high.
        raw_quarter = 1'b1; tick(1);
        raw_quarter = 1'b0; tick(1);
        raw_quarter = 1'b1; tick(2);
        raw_quarter = 1'b0; tick(1);
        raw_quarter = 1'b1;
        expect_pulse(K_QTR);
        tick(10);
        raw_quarter = 1'b0; tick(2);
        raw_quarter = 1'b1; tick(8);
        raw_quarter = 1'b0;
        flush("s2_pending");

        // 3. Simultaneous insertion, with and without accept_en.
        raw_dollar  = 1'b1;
        raw_quarter = 1'b1;
        expect_pulse(K_ERR);
        tick(12);
        raw_dollar  = 1'b0;
        raw_quarter = 1'b0;
        flush("s3_pending");
        accept_en   = 1'b0;
        raw_dollar  = 1'b1;
        raw_quarter = 1'b1;
        expect_pulse(K_ERR);
        tick(12);
        raw_dollar  = 1'b0;
        raw_quarter = 1'b0;
        flush("s3b_pending");

        // 4. Disabled quarter is rejected; re-inserted with enable it counts,
        //    even though accept_en dips low during the debounce window.
        accept_en   = 1'b0;
        raw_quarter = 1'b1;
        expect_pulse(K_ERR);
        tick(10);
        raw_quarter = 1'b0;
        accept_en   = 1'b1;
        tick(10);
        raw_quarter = 1'b1;
        expect_pulse(K_QTR);
        tick(2);
        accept_en   = 1'b0;
        tick(2);
        accept_en   = 1'b1;
        tick(8);
        raw_quarter = 1'b0;
        flush("s4_pending");

        // 5. Reset in the middle of a dollar debounce, sensor stuck high.
        raw_dollar = 1'b1;
        tick(3);
        rst = 1'b0;
        #1 check("async_reset", {coin_err, q_in, d_in}, 0);
        tick(3);
        rst = 1'b1;
        expect_pulse(K_DOL);
        tick(14);
        raw_dollar = 1'b0;
        flush("s5_pending");

        // 6. Three quarters separated by 12 low cycles.
        for (int i = 0; i < 3; i++) begin
            raw_quarter = 1'b1;
            expect_pulse(K_QTR);
            tick(8);
            raw_quarter = 1'b0;
            tick(12);
        end
        flush("s6_pending");

        // Back-to-back rises on different channels give adjacent pulses.
        raw_dollar = 1'b1;
        expect_pulse(K_DOL);
        tick(1);
        raw_quarter = 1'b1;
        expect_pulse(K_QTR);
        tick(10);
        raw_dollar  = 1'b0;
        raw_quarter = 1'b0;
        flush("b2b_pending");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coin_pulse_gen.md
Name: coin_pulse_gen

Overview:
Front-end stage that feeds the vending-machine controller its d_in (dollar) and q_in (quarter) inputs.
- Takes the raw, asynchronous, bouncy coin-sensor lines, synchronizes and debounces each one.
- Emits exactly one single-cycle pulse per accepted coin.
- Guarantees d_in and q_in are never high together and rejects ambiguous or disabled insertions via coin_err.

Parameters:
SYNC_STAGES, 2, flops in each per-channel synchronizer chain (legal values 2..3).
DEBOUNCE_CYCLES, 16, consecutive identical synchronized samples required to accept a level change (legal values 2..255).
CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
raw_dollar  input  1  dollar sensor line; asynchronous, may bounce; high = coin present.
raw_quarter  input  1  quarter sensor line; asynchronous, may bounce; high = coin present.
accept_en  input  1  synchronous enable; when low, coins are debounced but rejected.
d_in  output  1  registered single-cycle pulse, one per accepted dollar.
q_in  output  1  registered single-cycle pulse, one per accepted quarter.
coin_err  output  1  registered single-cycle pulse, one per rejected coin.

Behaviour:
- Reset (rst low, asynchronous):
  - All synchronizer flops, counters and outputs go to 0.
  - Both channel FSMs go to LOW_STABLE.
  - Reset asserted mid-debounce discards the partial count; no pulse is emitted.
- Synchronizer: SYNC_STAGES flops per channel. The last stage gives s_d / s_q. Nothing downstream samples a raw line directly.
- Per-channel debounce FSM, states LOW_STABLE, RISE_CHK, HIGH_STABLE, FALL_CHK, counter cnt:
  - LOW_STABLE: s=1 -> RISE_CHK, cnt=1. Otherwise hold.
  - RISE_CHK: s=0 -> LOW_STABLE, cnt=0 (bounce, no event). s=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH_STABLE, raise internal rise_q for one cycle. Otherwise cnt+1.
  - HIGH_STABLE: s=0 -> FALL_CHK, cnt=1. Otherwise hold. No further events while the sensor stays high.
  - FALL_CHK: s=1 -> HIGH_STABLE (bounce, no event). s=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW_STABLE. Otherwise cnt+1.
  - cnt never wraps; it saturates at DEBOUNCE_CYCLES-1 by construction.
- Latency: call edge 1 the first clk edge at which the raw line is high and stays high. The pulse is high during the cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES (18 cycles at defaults). Latency is fixed and identical for both channels.
- Arbitration, evaluated in the cycle the rise events occur, outputs registered:
  - Exactly one rise event and accept_en=1: the matching d_in or q_in pulses high for 1 cycle.
  - One rise event and accept_en=0: coin_err pulses; no coin pulse.
  - Both rise events in the same cycle (either accept_en value): coin_err pulses once; neither d_in nor q_in.
  - Rise events in different cycles are independent. Back-to-back cycles produce back-to-back pulses on different outputs.
- Invariants:
  - d_in & q_in == 0 always.
  - coin_err is never high in the same cycle as d_in or q_in.
  - Each output is high for at most 1 cycle per qualified rise event.
- Sensor stuck high through reset release: treated as a new insertion. It is fully debounced and produces one pulse; nothing more until it falls and rises again.
- accept_en is sampled only at the rise-event cycle. Toggling it during debounce has no other effect.

Decomposition:
- Package coin_pkg holds:
  - the 2-bit state encodings LOW_STABLE=2'b00, RISE_CHK=2'b01, HIGH_STABLE=2'b10, FALL_CHK=2'b11;
  - default values for SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module, coin_debounce: synchronizer, FSM and counter for a single channel, output rise_q. It is instantiated twice.
- Arbitration and output registers live in coin_pulse_gen.

Test Plan:
Run all scenarios with DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
1. Clean dollar: raw_dollar 0->1, held 20 cycles, accept_en=1 -> d_in high exactly 1 cycle, after edge 6; q_in and coin_err stay 0.
2. Bounce: raw_quarter toggles 1,0,1,1,0 over 5 cycles, then high for 10 -> exactly one q_in pulse, 6 edges after the final rise. A bounce of 2 low cycles during HIGH_STABLE gives no second pulse.
3. Simultaneous insertion: raw_dollar and raw_quarter rise on the same edge -> one coin_err pulse at edge 6; d_in=q_in=0 throughout.
4. Disabled: accept_en=0, clean quarter -> coin_err pulse, no q_in. Then accept_en=1, quarter released and reinserted -> q_in pulse.
5. Reset mid-operation: rst low at edge 4 of a dollar debounce, released, raw_dollar still high -> no pulse before release; one d_in pulse 6 edges after release.
6. Sequence for the vending controller: quarter, quarter, quarter separated by 12 low cycles -> three q_in pulses, each exactly 1 cycle, never overlapping d_in.
